// File: rtl/exception_unit_pkg.sv
// Shared definitions for the exception unit and the decode control that feeds it:
// FSM states, cause codes, the default vector and the pc_in select encodings.
package exception_unit_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLUSH   = 2'd1,
      HANDLER = 2'd2,
      RETURN  = 2'd3
   } state_t;

   localparam logic [3:0] CAUSE_NONE = 4'h0;
   localparam logic [3:0] CAUSE_MEM  = 4'h1;
   localparam logic [3:0] CAUSE_ALU  = 4'h2;
   localparam logic [3:0] CAUSE_BOTH = 4'h3;

   localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0080;

   // Decode-control PC mux select; PCSEL_EXC picks this unit's redirect_pc.
   typedef enum logic [1:0] {
      PCSEL_SEQ    = 2'd0,
      PCSEL_BRANCH = 2'd1,
      PCSEL_JUMP   = 2'd2,
      PCSEL_EXC    = 2'd3
   } pc_in_sel_t;

   function automatic logic [3:0] cause_encode(input logic i_exc1, input logic i_exc2);
      logic [3:0] w_code;
      if (i_exc1 && i_exc2)  w_code = CAUSE_BOTH;
      else if (i_exc1)       w_code = CAUSE_MEM;
      else if (i_exc2)       w_code = CAUSE_ALU;
      else                   w_code = CAUSE_NONE;
      return w_code;
   endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Strobe/bus bundle between the two-slot decode control (master) and the exception unit (slave).
interface exception_unit_if #(
   parameter int PC_W    = 32,
   parameter int CAUSE_W = 4
);
   logic               exception1;
   logic               exception2;
   logic               EPCWrite1;
   logic               EPCWrite2;
   logic               causeWrite1;
   logic               causeWrite2;
   logic [PC_W-1:0]    pc_id;
   logic               eret;
   logic [PC_W-1:0]    epc;
   logic [CAUSE_W-1:0] cause;
   logic               pc_redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic               pipe_flush;
   logic               in_handler;
   logic               double_fault;

   modport master (
      output exception1, exception2, EPCWrite1, EPCWrite2, causeWrite1, causeWrite2,
             pc_id, eret,
      input  epc, cause, pc_redirect, redirect_pc, pipe_flush, in_handler, double_fault
   );

   modport slave (
      input  exception1, exception2, EPCWrite1, EPCWrite2, causeWrite1, causeWrite2,
             pc_id, eret,
      output epc, cause, pc_redirect, redirect_pc, pipe_flush, in_handler, double_fault
   );
endinterface

// File: rtl/exception_unit_flush_counter.sv
// Loadable down-counter that times the flush window after a redirect; done when it reaches zero.
module exception_unit_flush_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_done
);
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/exception_unit.sv
// Exception unit: captures EPC/cause, redirects to the handler vector or back on eret,
// and times the pipeline flush that follows every redirect.
module exception_unit
   import exception_unit_pkg::*;
#(
   parameter int          PC_W         = 32,
   parameter int          CAUSE_W      = 4,
   parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
   parameter int          RET_OFFSET   = 8,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   exception_unit_if.slave  bus
);
   localparam int              CNT_W      = 4;
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_t             r_state, w_state_nxt;
   logic [PC_W-1:0]    r_epc, w_epc_nxt;
   logic [CAUSE_W-1:0] r_cause, w_cause_nxt;
   logic [PC_W-1:0]    r_redirect_pc, w_redirect_pc_nxt;
   logic               r_pc_redirect, w_pc_redirect_nxt;
   logic               r_pipe_flush, w_pipe_flush_nxt;
   logic               r_in_handler, w_in_handler_nxt;
   logic               r_double_fault, w_double_fault_nxt;
   logic               r_from_ret, w_from_ret_nxt;

   logic               w_any_exc;
   logic               w_epc_we;
   logic               w_cause_we;
   logic [CAUSE_W-1:0] w_cause_code;
   logic               w_cnt_load;
   logic               w_cnt_done;

   assign w_any_exc    = bus.exception1 | bus.exception2;
   // A write enable only counts when its own slot actually faulted.
   assign w_epc_we     = (bus.EPCWrite1 & bus.exception1) | (bus.EPCWrite2 & bus.exception2);
   assign w_cause_we   = (bus.causeWrite1 & bus.exception1) | (bus.causeWrite2 & bus.exception2);
   assign w_cause_code = CAUSE_W'(cause_encode(bus.exception1, bus.exception2));

   exception_unit_flush_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_cnt_load),
      .i_load_val (FLUSH_LOAD),
      .o_done     (w_cnt_done)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_epc          <= '0;
         r_cause        <= '0;
         r_redirect_pc  <= '0;
         r_pc_redirect  <= 1'b0;
         r_pipe_flush   <= 1'b0;
         r_in_handler   <= 1'b0;
         r_double_fault <= 1'b0;
         r_from_ret     <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_epc          <= w_epc_nxt;
         r_cause        <= w_cause_nxt;
         r_redirect_pc  <= w_redirect_pc_nxt;
         r_pc_redirect  <= w_pc_redirect_nxt;
         r_pipe_flush   <= w_pipe_flush_nxt;
         r_in_handler   <= w_in_handler_nxt;
         r_double_fault <= w_double_fault_nxt;
         r_from_ret     <= w_from_ret_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_epc_nxt          = r_epc;
      w_cause_nxt        = r_cause;
      w_redirect_pc_nxt  = r_redirect_pc;
      w_pc_redirect_nxt  = 1'b0;
      w_pipe_flush_nxt   = r_pipe_flush;
      w_in_handler_nxt   = r_in_handler;
      w_double_fault_nxt = r_double_fault;
      w_from_ret_nxt     = r_from_ret;
      w_cnt_load         = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (w_any_exc) begin
               if (w_epc_we)   w_epc_nxt   = bus.pc_id;
               if (w_cause_we) w_cause_nxt = w_cause_code;
               w_pc_redirect_nxt = 1'b1;
               w_redirect_pc_nxt = PC_W'(HANDLER_ADDR);
               w_pipe_flush_nxt  = 1'b1;
               w_from_ret_nxt    = 1'b0;
               w_cnt_load        = 1'b1;
               w_state_nxt       = FLUSH;
            end
         end
         FLUSH: begin
            // Strobes seen here belong to squashed bundles and are dropped.
            if (w_cnt_done) begin
               w_pipe_flush_nxt = 1'b0;
               w_in_handler_nxt = !r_from_ret;
               w_state_nxt      = r_from_ret ? IDLE : HANDLER;
            end
         end
         HANDLER: begin
            if (w_any_exc) begin
               w_double_fault_nxt = 1'b1;
               w_pc_redirect_nxt  = 1'b1;
               w_redirect_pc_nxt  = PC_W'(HANDLER_ADDR);
               w_pipe_flush_nxt   = 1'b1;
               w_from_ret_nxt     = 1'b0;
               w_cnt_load         = 1'b1;
               w_state_nxt        = FLUSH;
            end else if (bus.eret) begin
               w_pc_redirect_nxt = 1'b1;
               w_redirect_pc_nxt = r_epc + PC_W'(RET_OFFSET);
               w_pipe_flush_nxt  = 1'b1;
               w_in_handler_nxt  = 1'b0;
               w_from_ret_nxt    = 1'b1;
               w_cnt_load        = 1'b1;
               w_state_nxt       = RETURN;
            end
         end
         RETURN: begin
            // RETURN is the first cycle of the return flush window.
            if (w_cnt_done) begin
               w_pipe_flush_nxt = 1'b0;
               w_state_nxt      = IDLE;
            end else begin
               w_state_nxt = FLUSH;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.epc          = r_epc;
   assign bus.cause        = r_cause;
   assign bus.redirect_pc  = r_redirect_pc;
   assign bus.pc_redirect  = r_pc_redirect;
   assign bus.pipe_flush   = r_pipe_flush;
   assign bus.in_handler   = r_in_handler;
   assign bus.double_fault = r_double_fault;

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Sequential consumer of the per-slot exception, EPC-write and cause-write strobes produced by the two-slot decode control (memory slot = 1, ALU slot = 2).
- Captures the faulting bundle PC into EPC and the cause code, and issues a one-cycle PC redirect to the handler vector.
- Sequences pipeline flushes and tracks handler residency.
- Performs the return redirect on eret.
- Sits between the decode control and the PC/IF-ID pipeline registers.

Parameters:
- PC_W, 32, program counter and EPC width
- CAUSE_W, 4, cause register width
- HANDLER_ADDR, 32'h0000_0080, exception vector address
- RET_OFFSET, 8, bytes added to EPC on return (one two-slot bundle)
- FLUSH_CYCLES, 2, cycles flush stays asserted after a redirect (min 1, max 15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- exception1  in  1  memory-slot exception
- exception2  in  1  ALU-slot exception
- EPCWrite1  in  1  memory-slot EPC capture enable
- EPCWrite2  in  1  ALU-slot EPC capture enable
- causeWrite1  in  1  memory-slot cause capture enable
- causeWrite2  in  1  ALU-slot cause capture enable
- pc_id  in  PC_W  PC of the bundle currently in decode
- eret  in  1  return-from-exception request (decoded in handler code)
- epc  out  PC_W  captured exception PC
- cause  out  CAUSE_W  captured cause code
- pc_redirect  out  1  one-cycle strobe: PC loads redirect_pc
- redirect_pc  out  PC_W  redirect target
- pipe_flush  out  1  flush the IF/ID and ID/EX registers
- in_handler  out  1  handler is executing
- double_fault  out  1  sticky: exception raised while in the handler

Behaviour:
- Reset (reset==0 at a clk edge):
  - state<=IDLE.
  - epc, cause, redirect_pc <= 0.
  - pc_redirect, pipe_flush, in_handler, double_fault <= 0.
  - flush counter <= 0.
  - Reset mid-sequence aborts immediately; it is the only way to clear double_fault.
- Any exception = exception1|exception2.
- Cause encoding:
  - 4'h1 = slot 1 only.
  - 4'h2 = slot 2 only.
  - 4'h3 = both slots.
  - 4'h0 = none.
  - Upper bits are zero.
- States: IDLE, FLUSH, HANDLER, RETURN.
- IDLE:
  - Any exception at edge N:
    - epc<=pc_id if EPCWrite1|EPCWrite2.
    - cause<=encoding if causeWrite1|causeWrite2; a write-enable without its exception leaves the register unchanged.
  - Outputs registered at N (visible in cycle N+1):
    - pc_redirect=1 for exactly one cycle.
    - redirect_pc=HANDLER_ADDR.
    - pipe_flush=1.
    - state->FLUSH with counter=FLUSH_CYCLES-1.
  - eret in IDLE is ignored: no redirect, no flag.
- FLUSH:
  - pipe_flush held high.
  - Counter decrements each cycle; at 0, pipe_flush deasserts and state->HANDLER (or ->IDLE if the flush was initiated from RETURN).
  - Exceptions and eret during FLUSH are ignored; they come from squashed bundles.
  - Total pipe_flush high time = FLUSH_CYCLES cycles.
- HANDLER:
  - in_handler=1.
  - Exception:
    - double_fault<=1.
    - EPC and cause are not overwritten.
    - Redirect to HANDLER_ADDR again, then FLUSH->HANDLER.
  - eret without exception:
    - pc_redirect=1 with redirect_pc=epc+RET_OFFSET; the add is modulo 2^PC_W and wraps silently.
    - pipe_flush=1, state->RETURN.
  - Simultaneous exception and eret: the exception wins (double-fault path) and eret is dropped.
- RETURN:
  - in_handler deasserts.
  - Enters the FLUSH sequence, ending in IDLE.
  - epc and cause retain their values until the next capture.
- pc_redirect is never high in two consecutive cycles.

Decomposition:
- Shared package holds:
  - state enum (IDLE/FLUSH/HANDLER/RETURN).
  - cause code constants CAUSE_NONE/CAUSE_MEM/CAUSE_ALU/CAUSE_BOTH.
  - default HANDLER_ADDR.
- Decode-control pc_in select encodings also go in the package so both ends share them.
- One natural sub-module, flush_counter: a loadable down-counter with a done flag, reused for both post-redirect flush sequences.

Test Plan:
- Reset hold: reset=0 for 3 cycles with exception1=1, pc_id=32'h40 -> all outputs 0, epc=0, state IDLE after release.
- Slot-1 fault: reset=1, exception1=EPCWrite1=causeWrite1=1, pc_id=32'h100 for one cycle -> next cycle pc_redirect=1, redirect_pc=32'h80, epc=32'h100, cause=4'h1, pipe_flush high exactly 2 cycles, then in_handler=1.
- Both slots: exception1=exception2=1 with all write-enables at pc_id=32'h200 -> cause=4'h3, epc=32'h200; exceptions re-asserted during FLUSH produce no second redirect.
- Return: in HANDLER with epc=32'h200, pulse eret -> one-cycle pc_redirect with redirect_pc=32'h208, in_handler=0 next cycle, 2 flush cycles, then IDLE; eret pulsed again in IDLE -> no redirect.
- Double fault: in HANDLER, assert exception2 and eret simultaneously with pc_id=32'h300 -> double_fault=1, redirect_pc=32'h80, epc unchanged at 32'h200, cause unchanged.
- Wrap: epc=32'hFFFF_FFFC, then eret -> redirect_pc=32'h0000_0004.
